// File: rtl/fnd_display_scheduler_pkg.sv
// rtl/fnd_display_scheduler_pkg.sv - shared types, constants and segment table for the FND scheduler
package fnd_display_scheduler_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} conv_state_e;
  typedef enum logic {BALANCE, ANIM} disp_mode_e;

  localparam logic [7:0]  SEG_BLANK = 8'hFF;
  localparam logic [3:0]  AN_OFF    = 4'b1111;
  localparam logic [13:0] BIN_MAX   = 14'd9999;

  // Common-anode codes {dp,g,f,e,d,c,b,a}, 0 = lit; entry 9 is leftmost.
  localparam logic [9:0][7:0] SEG_TABLE = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] s;
    s = SEG_BLANK;
    for (int i = 0; i < 10; i++) begin
      if (d == 4'(i)) s = SEG_TABLE[i];
    end
    return s;
  endfunction

endpackage

// File: rtl/fnd_display_scheduler_bin2bcd_seq.sv
// rtl/fnd_display_scheduler_bin2bcd_seq.sv - sequential 14-bit binary to 4-digit BCD converter (double dabble)
module bin2bcd_seq
  import fnd_display_scheduler_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd
);

  conv_state_e state_q;
  logic [13:0] op_q;
  logic [29:0] sr_q;
  logic [29:0] sr_adj;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] bcd_q;

  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < 4; i++) begin
      if (sr_q[14+4*i +: 4] >= 4'd5) sr_adj[14+4*i +: 4] = sr_q[14+4*i +: 4] + 4'd3;
    end
  end

  // bcd_q only changes in COMMIT so the display never sees a half-converted value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q    <= bin;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          sr_q    <= {16'd0, op_q};
          cnt_q   <= '0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          sr_q  <= {sr_adj[28:0], 1'b0};
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd13) begin
            done_q  <= 1'b1;
            state_q <= COMMIT;
          end
        end
        COMMIT: begin
          bcd_q   <= sr_q[29:14];
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/fnd_display_scheduler.sv
// rtl/fnd_display_scheduler.sv - 4-digit FND multiplexer with BCD conversion and animation override
// Optional: FND_LEADING_ZERO_BLANK_EN blanks leading zero digits in BALANCE mode.
module fnd_display_scheduler
  import fnd_display_scheduler_pkg::*;
#(
  parameter int SCAN_CYCLES  = 100_000,
  parameter int BLANK_CYCLES = 2_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [13:0] display_data,
  input  logic        coffee_making_flag,
  input  logic [7:0]  animation_seg,
  input  logic [3:0]  animation_an,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        conv_busy
);

  localparam int CW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  logic [13:0]   clamped;
  logic [13:0]   pend_q;
  logic [13:0]   committed_q;
  logic          start;
  logic          done;
  logic [15:0]   bcd;
  logic [CW-1:0] scan_q;
  logic [1:0]    idx_q;
  disp_mode_e    mode_q;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic [3:0]    digit;

  assign clamped = (display_data > BIN_MAX) ? BIN_MAX : display_data;
  assign start   = !conv_busy && (clamped != committed_q);

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .bin     (clamped),
    .busy    (conv_busy),
    .done    (done),
    .bcd     (bcd)
  );

`ifdef FND_LEADING_ZERO_BLANK_EN
  logic [3:0] lz;
  always_comb begin
    lz[3] = (bcd[15:12] == 4'd0);
    lz[2] = lz[3] && (bcd[11:8] == 4'd0);
    lz[1] = lz[2] && (bcd[7:4] == 4'd0);
    lz[0] = 1'b0;
  end
`endif

  always_comb begin
    digit = bcd[{idx_q, 2'b00} +: 4];
    seg_d = SEG_BLANK;
    an_d  = AN_OFF;
    if (mode_q == ANIM) begin
      seg_d = animation_seg;
      an_d  = animation_an;
    end else if (scan_q >= BLANK_END) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = seg_code(digit);
`ifdef FND_LEADING_ZERO_BLANK_EN
      if (lz[idx_q]) seg_d = SEG_BLANK;
`endif
    end
  end

  // Mode is only sampled at the slot wrap so a digit slot is never split between sources.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_q      <= '0;
      idx_q       <= '0;
      mode_q      <= BALANCE;
      seg_q       <= SEG_BLANK;
      an_q        <= AN_OFF;
      pend_q      <= '0;
      committed_q <= '0;
    end else begin
      if (scan_q == SCAN_LAST) begin
        scan_q <= '0;
        idx_q  <= idx_q + 2'd1;
        mode_q <= coffee_making_flag ? ANIM : BALANCE;
      end else begin
        scan_q <= scan_q + CW'(1);
      end
      seg_q <= seg_d;
      an_q  <= an_d;
      if (start) pend_q <= clamped;
      if (done) committed_q <= pend_q;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule
